// File: rtl/tdm_demux2_if.sv
// rtl/tdm_demux2_if.sv - serial input and demultiplexed word outputs of tdm_demux2
interface tdm_demux2_if #(
    parameter int WIDTH = 4
);
    logic             in_s;
    logic             in_valid;
    logic             frame_start;
    logic [WIDTH-1:0] out_ch0;
    logic [WIDTH-1:0] out_ch1;
    logic             out_valid;
    logic             out_select;
    logic             busy;
    logic             frame_err;

    modport master (
        output in_s, in_valid, frame_start,
        input  out_ch0, out_ch1, out_valid, out_select, busy, frame_err
    );

    modport slave (
        input  in_s, in_valid, frame_start,
        output out_ch0, out_ch1, out_valid, out_select, busy, frame_err
    );
endinterface

// File: rtl/tdm_demux2.sv
// rtl/tdm_demux2.sv - two-channel bit-interleaved TDM demultiplexer and word assembler
module tdm_demux2 #(
    parameter int WIDTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    tdm_demux2_if.slave  bus
);
    localparam int CW = (2 * WIDTH > 1) ? $clog2(2 * WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(2 * WIDTH - 1);

    typedef enum logic {IDLE, RECV} state_t;

    state_t           state, state_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [WIDTH-1:0] acc0, acc0_n, acc1, acc1_n;
    logic [WIDTH-1:0] ch0, ch0_n, ch1, ch1_n;
    logic             ov, ov_n, fe, fe_n;
    logic [WIDTH-1:0] mask, acc0_w, acc1_w;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            acc0  <= '0;
            acc1  <= '0;
            ch0   <= '0;
            ch1   <= '0;
            ov    <= 1'b0;
            fe    <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            acc0  <= acc0_n;
            acc1  <= acc1_n;
            ch0   <= ch0_n;
            ch1   <= ch1_n;
            ov    <= ov_n;
            fe    <= fe_n;
        end
    end

    // Even count feeds channel 0, odd feeds channel 1; word position is cnt/2, LSB first.
    always_comb begin
        mask   = WIDTH'(1) << (cnt >> 1);
        acc0_w = bus.in_s ? (acc0 | mask) : (acc0 & ~mask);
        acc1_w = bus.in_s ? (acc1 | mask) : (acc1 & ~mask);
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        acc0_n  = acc0;
        acc1_n  = acc1;
        ch0_n   = ch0;
        ch1_n   = ch1;
        ov_n    = 1'b0;
        fe_n    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.in_valid && bus.frame_start) begin
                    acc0_n  = WIDTH'(bus.in_s);
                    acc1_n  = '0;
                    cnt_n   = CW'(1);
                    state_n = RECV;
                end
            end
            RECV: begin
                if (bus.in_valid) begin
                    if (bus.frame_start) begin
                        // Early restart: drop the partial frame, this bit opens a new one.
                        fe_n   = 1'b1;
                        acc0_n = WIDTH'(bus.in_s);
                        acc1_n = '0;
                        cnt_n  = CW'(1);
                    end else if (cnt == LAST) begin
                        acc1_n  = acc1_w;
                        ch0_n   = acc0;
                        ch1_n   = acc1_w;
                        ov_n    = 1'b1;
                        cnt_n   = '0;
                        state_n = IDLE;
                    end else begin
                        if (cnt[0]) begin
                            acc1_n = acc1_w;
                        end else begin
                            acc0_n = acc0_w;
                        end
                        cnt_n = cnt + CW'(1);
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.out_ch0    = ch0;
    assign bus.out_ch1    = ch1;
    assign bus.out_valid  = ov;
    assign bus.frame_err  = fe;
    assign bus.busy       = (state == RECV);
    assign bus.out_select = cnt[0];
endmodule

// File: tb/tb_tdm_demux2.sv
// tb/tb_tdm_demux2.sv - randomized and directed bench for tdm_demux2 at WIDTH 4 and 1
module tb_tdm_demux2;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    tdm_demux2_if #(.WIDTH(4)) bus4();
    tdm_demux2_if #(.WIDTH(1)) bus1();

    tdm_demux2 #(.WIDTH(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4));
    tdm_demux2 #(.WIDTH(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

    int n_tests = 0;
    int n_fail  = 0;

    // Reference: collect the frame's raw serial bits, then split even/odd into words.
    bit       m_in  [2];
    int       m_n   [2];
    bit [7:0] m_buf [2];
    bit [3:0] m_ch0 [2];
    bit [3:0] m_ch1 [2];
    bit       m_ov  [2];
    bit       m_fe  [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_in[k] = 0; m_n[k] = 0; m_buf[k] = '0;
            m_ch0[k] = '0; m_ch1[k] = '0; m_ov[k] = 0; m_fe[k] = 0;
        end
    endtask

    task automatic model_step(input int k, input bit v, input bit fs, input bit s);
        int w;
        w = (k == 0) ? 4 : 1;
        m_ov[k] = 0;
        m_fe[k] = 0;
        if (v) begin
            if (fs) begin
                if (m_in[k]) m_fe[k] = 1;
                m_in[k]  = 1;
                m_buf[k] = '0;
                m_buf[k][0] = s;
                m_n[k]   = 1;
            end else if (m_in[k]) begin
                m_buf[k][m_n[k]] = s;
                m_n[k]++;
                if (m_n[k] == 2 * w) begin
                    m_ch0[k] = '0;
                    m_ch1[k] = '0;
                    for (int i = 0; i < w; i++) begin
                        m_ch0[k][i] = m_buf[k][2 * i];
                        m_ch1[k][i] = m_buf[k][2 * i + 1];
                    end
                    m_ov[k] = 1;
                    m_in[k] = 0;
                    m_n[k]  = 0;
                end
            end
        end
    endtask

    task automatic check_outputs();
        check("w4_ch0",   32'(bus4.out_ch0),    32'(m_ch0[0]));
        check("w4_ch1",   32'(bus4.out_ch1),    32'(m_ch1[0]));
        check("w4_valid", 32'(bus4.out_valid),  32'(m_ov[0]));
        check("w4_err",   32'(bus4.frame_err),  32'(m_fe[0]));
        check("w4_busy",  32'(bus4.busy),       32'(m_in[0]));
        check("w4_sel",   32'(bus4.out_select), 32'(m_in[0] ? (m_n[0] % 2) : 0));
        check("w1_ch0",   32'(bus1.out_ch0),    32'(m_ch0[1]));
        check("w1_ch1",   32'(bus1.out_ch1),    32'(m_ch1[1]));
        check("w1_valid", 32'(bus1.out_valid),  32'(m_ov[1]));
        check("w1_err",   32'(bus1.frame_err),  32'(m_fe[1]));
        check("w1_busy",  32'(bus1.busy),       32'(m_in[1]));
        check("w1_sel",   32'(bus1.out_select), 32'(m_in[1] ? (m_n[1] % 2) : 0));
    endtask

    task automatic send(input bit v, input bit fs, input bit s);
        bus4.in_valid = v; bus4.frame_start = fs; bus4.in_s = s;
        bus1.in_valid = v; bus1.frame_start = fs; bus1.in_s = s;
        @(posedge clk);
        model_step(0, v, fs, s);
        model_step(1, v, fs, s);
        #1;
        check_outputs();
    endtask

    // Sends the first nbits of a WIDTH-4 frame carrying words w0/w1, optional gap before bit 3.
    task automatic send_frame(input bit [3:0] w0, input bit [3:0] w1, input int gap, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            if (i == 3) begin
                for (int g = 0; g < gap; g++) begin
                    send(0, 1, 1);
                    check("gap_busy", 32'(bus4.busy), 32'd1);
                end
            end
            send(1, (i == 0), (i % 2 == 0) ? w0[i / 2] : w1[i / 2]);
        end
    endtask

    initial begin
        reset = 1'b1;
        bus4.in_valid = 0; bus4.frame_start = 0; bus4.in_s = 0;
        bus1.in_valid = 0; bus1.frame_start = 0; bus1.in_s = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_outputs();
        reset = 1'b0;

        send(0, 0, 0);
        send_frame(4'hA, 4'h5, 0, 8);
        check("basic_valid", 32'(bus4.out_valid), 32'd1);
        check("basic_ch0",   32'(bus4.out_ch0),   32'hA);
        check("basic_ch1",   32'(bus4.out_ch1),   32'h5);
        send(0, 0, 0);
        check("basic_pulse", 32'(bus4.out_valid), 32'd0);

        send_frame(4'h6, 4'h9, 3, 8);
        check("gap_ch0", 32'(bus4.out_ch0), 32'h6);
        check("gap_ch1", 32'(bus4.out_ch1), 32'h9);

        send_frame(4'h3, 4'hC, 0, 5);
        send(1, 1, 1);
        check("early_err", 32'(bus4.frame_err), 32'd1);
        check("early_hold", 32'(bus4.out_ch0), 32'h6);
        for (int i = 0; i < 7; i++) send(1, 0, 1);
        check("early_ch0", 32'(bus4.out_ch0), 32'hF);
        check("early_ch1", 32'(bus4.out_ch1), 32'hF);

        send_frame(4'hA, 4'h5, 0, 8);
        check("b2b1_ch0", 32'(bus4.out_ch0), 32'hA);
        send_frame(4'h3, 4'hC, 0, 8);
        check("b2b2_valid", 32'(bus4.out_valid), 32'd1);
        check("b2b2_ch0", 32'(bus4.out_ch0), 32'h3);
        check("b2b2_ch1", 32'(bus4.out_ch1), 32'hC);

        send_frame(4'h3, 4'hC, 0, 7);
        send(1, 1, 0);
        check("last_pos_err", 32'(bus4.frame_err), 32'd1);
        for (int i = 0; i < 7; i++) send(1, 0, 0);
        check("last_pos_ch0", 32'(bus4.out_ch0), 32'h0);

        for (int i = 0; i < 5; i++) send(1, 0, i[0]);
        check("stray_busy", 32'(bus4.busy), 32'd0);

        send(1, 1, 1);
        send(1, 0, 0);
        check("w1_word0", 32'(bus1.out_ch0), 32'd1);
        check("w1_word1", 32'(bus1.out_ch1), 32'd0);
        check("w1_pulse", 32'(bus1.out_valid), 32'd1);

        send_frame(4'h5, 4'hA, 0, 3);
        bus4.in_valid = 0; bus1.in_valid = 0;
        reset = 1'b1;
        #1;
        model_reset();
        check_outputs();
        check("rst_busy", 32'(bus4.busy), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        send(0, 0, 0);

        for (int f = 0; f < 30; f++) begin
            send_frame(4'($urandom), 4'($urandom), int'($urandom_range(0, 2)), 8);
            if ($urandom_range(0, 3) == 0) send(0, 0, 0);
        end
        for (int c = 0; c < 600; c++) begin
            send($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0, 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
